seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative restoring divider for the MAC datapath; the inverse of the multiply-accumulate path.
- Produces quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Each step uses a ripple subtractor built from full-subtractor cells, the counterpart of the full-adder cells used in the accumulator.
- Start/Done handshake toward the MAC controller.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (must be >= 2).

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst_n  input  1  synchronous active-low reset
Start  input  1  request; sampled only in IDLE
Dividend  input  WIDTH  dividend, captured on accepted Start
Divisor  input  WIDTH  divisor, captured on accepted Start
Busy  output  1  high while in RUN
Done  output  1  one-cycle pulse, results valid
Quotient  output  WIDTH  quotient, held until next accepted Start
Remainder  output  WIDTH  remainder, held until next accepted Start
DivByZero  output  1  set with Done when Divisor was 0, held like Quotient

Behaviour:
- Interface: one clock (Clk); reset Rst_n is synchronous and active-low.
- Reset (Rst_n=0 at an edge):
  - State goes to IDLE.
  - Busy, Done, DivByZero, Quotient and Remainder all clear to 0.
  - Reset applies in any state, including mid-RUN. The partial result is discarded and there is no Done.
- States and transitions:
  - IDLE:
    - Start=1 at edge t captures the operands and clears the partial remainder and counter.
    - If Divisor != 0: go to RUN.
    - If Divisor == 0: go to FINISH.
  - RUN (Busy=1): one restoring step per edge.
    - Shift {rem, dividend MSB} left.
    - Trial-subtract the divisor with a (WIDTH+1)-bit subtractor.
    - No borrow: keep the difference and shift in quotient bit 1.
    - Borrow: restore and shift in quotient bit 0.
    - A counter runs from 0 to WIDTH-1. After the step with count WIDTH-1 (edge t+WIDTH), go to FINISH.
  - FINISH:
    - Results are registered on entry.
    - Done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Normal: Done is high in the cycle after edge t+WIDTH (WIDTH+1 clocks from Start sample).
  - Divide-by-zero: Done is high in the cycle after edge t+1.
- Divide-by-zero results: Quotient = all ones, Remainder = Dividend, DivByZero=1.
- DivByZero clears on the next accepted Start.
- Start is ignored in RUN and FINISH, and operand changes there have no effect. Start is sampled again in IDLE, the cycle after Done.
- Operands only need to be stable at the accepting edge.
- Width rule:
  - Internal partial remainder is WIDTH+1 bits. The borrow is its MSB.
  - Outputs are truncated to WIDTH. Remainder < Divisor always holds for Divisor != 0.

Optional Feature:
SIGNED_DIV_EN
- Defined:
  - Operands are two's complement.
  - Magnitudes are taken at capture and divided as unsigned.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the Dividend (truncating division).
  - Sign fix-up is applied when writing results, so latency is unchanged.
  - Overflow case (most-negative / -1): Quotient = most-negative (wraps), Remainder = 0, DivByZero=0.
  - Divide-by-zero: Quotient = all ones, Remainder = Dividend.
- Undefined: purely unsigned, no sign logic synthesized.

Decomposition:
- Package div_pkg:
  - State enum (IDLE, RUN, FINISH).
  - Default WIDTH constant.
  - Counter width constant $clog2(WIDTH).
- Sub-module ripple_subtractor:
  - Parameterised N-bit A−B built from full-subtractor cells.
  - Outputs Diff[N-1:0] and Bout.
  - Instantiated once at N=WIDTH+1.

Test Plan (WIDTH=8):
- Dividend=200, Divisor=7, Start pulse → Busy for 8 cycles, Done 9 clocks after Start sample; Quotient=28, Remainder=4, DivByZero=0.
- 5/9 → Quotient=0, Remainder=5; 255/1 → Quotient=255, Remainder=0; 255/255 → Quotient=1, Remainder=0.
- 37/0 → Done 2 clocks after Start; DivByZero=1, Quotient=0xFF, Remainder=37. Next 10/3 clears DivByZero; Quotient=3, Remainder=1.
- Start 100/3. At RUN cycle 3, assert Start with 9/9 → ignored; result Quotient=33, Remainder=1. Then repeat 100/3 with Rst_n=0 at RUN cycle 4 → all outputs 0 next cycle, no Done.
- Back-to-back: Start held high continuously → new operation accepted the cycle after each Done pulse; Done pulses spaced WIDTH+2 clocks apart.
- SIGNED_DIV_EN: -100/7 → Quotient=0xF2 (-14), Remainder=0xFE (-2); 100/-7 → 0xF2, 0x02; -128/-1 → Quotient=0x80, Remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and counter sizing helper.
package div_pkg;

  // Default operand / quotient / remainder width.
  localparam int DIV_WIDTH = 8;

  // Step counter width for the default operand width.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // Step counter width for an arbitrary operand width (never below 1 bit).
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ripple_subtractor.sv
// N-bit ripple-borrow subtractor (A - B) built from full-subtractor cells.
// Bout is the borrow out of the most significant cell.
module ripple_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Diff,
  output logic         Bout
);

  logic [N:0] borrow_s;

  assign borrow_s[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_fs
      // Full-subtractor cell: difference bit and borrow into the next cell.
      assign Diff[i]       = A[i] ^ B[i] ^ borrow_s[i];
      assign borrow_s[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow_s[i]);
    end
  endgenerate

  assign Bout = borrow_s[N];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, with a Start/Done
// handshake. Optional two's-complement operation is enabled by defining the
// macro SIGNED_DIV_EN; the default build is purely unsigned.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;   // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   sub_diff_s;
  logic             sub_bout_s;
  logic             qbit_s;
  logic [WIDTH:0]   step_rem_s;
  logic [WIDTH-1:0] step_quo_s;

`ifdef SIGNED_DIV_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // Magnitude of a two's-complement value; the most negative value maps to
  // its unsigned magnitude, which the unsigned datapath handles exactly.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ~v + WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Conditional two's-complement negation used for the result fix-up.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic             n);
    logic [WIDTH-1:0] r;
    if (n) begin
      r = ~v + WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction
`endif

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign shifted_s = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

  ripple_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .A    (shifted_s),
    .B    ({1'b0, dvs_q}),
    .Diff (sub_diff_s),
    .Bout (sub_bout_s)
  );

  // Restoring step: keep the difference when no borrow, otherwise restore.
  always_comb begin
    qbit_s     = ~sub_bout_s;
    step_quo_s = {dvd_q[WIDTH-2:0], qbit_s};
    if (sub_bout_s) begin
      step_rem_s = shifted_s;
    end else begin
      step_rem_s = sub_diff_s;
    end
  end

  // Next-state, datapath and result logic for the IDLE/RUN/FINISH sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
`ifdef SIGNED_DIV_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          rem_d = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
`ifdef SIGNED_DIV_EN
          qneg_d = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
          rneg_d = Dividend[WIDTH-1];
          dvs_d  = abs_val(Divisor);
`else
          dvs_d  = Divisor;
`endif
          if (Divisor != '0) begin
`ifdef SIGNED_DIV_EN
            dvd_d = abs_val(Dividend);
`else
            dvd_d = Dividend;
`endif
            state_d = RUN;
          end else begin
            // Raw dividend is kept: it is returned as the remainder.
            dvd_d   = Dividend;
            state_d = FINISH;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        rem_d = step_rem_s;
        dvd_d = step_quo_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Results are written on entry to FINISH so Done and data align.
`ifdef SIGNED_DIV_EN
          quo_d = neg_if(step_quo_s, qneg_q);
          rmd_d = neg_if(step_rem_s[WIDTH-1:0], rneg_q);
`else
          quo_d = step_quo_s;
          rmd_d = step_rem_s[WIDTH-1:0];
`endif
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          state_d = RUN;
        end
      end

      FINISH: begin
        if (done_q) begin
          // Done has been shown for its one cycle.
          state_d = IDLE;
        end else begin
          // Arrived straight from IDLE with a zero divisor.
          quo_d   = '1;
          rmd_d   = dvd_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SIGNED_DIV_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Quotient  = quo_q;
  assign Remainder = rmd_q;
  assign DivByZero = dbz_q;

endmodule
